cia_multiword_adder: RTL and testbench



---
 rtl/cia_pkg.sv | 11 +
 rtl/CIA_Var_Size.sv | 26 ++
 rtl/cia_multiword_adder.sv | 78 +++++++
 tb/tb_cia_multiword_adder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cia_pkg.sv
// cia_pkg: shared state encoding, default chunk width and index sizing for the multiword adder
package cia_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int N_DEF = 64;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/CIA_Var_Size.sv
// CIA_Var_Size: combinational carry-increment adder, 1-based vectors, 4-bit increment groups
module CIA_Var_Size #(
    parameter int N = 64
) (
    output logic [N:1] sum,
    output logic       cout,
    input  logic [N:1] a,
    input  logic [N:1] b,
    input  logic       cin
);
    localparam int G  = 4;
    localparam int NG = (N + G - 1) / G;
    logic [NG:0] c;
    assign c[0] = cin;
    assign cout = c[NG];
    for (genvar g = 0; g < NG; g++) begin : grp
        localparam int LO = g * G + 1;
        localparam int HI = (LO + G - 1 > N) ? N : LO + G - 1;
        localparam int WD = HI - LO + 1;
        logic [WD:0] r;
        // each group adds with zero carry-in, then the incoming carry is applied as an increment
        assign r = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]};
        assign sum[HI:LO] = r[WD-1:0] + WD'(c[g]);
        assign c[g+1] = r[WD] | (c[g] & (&r[WD-1:0]));
    end
endmodule

// File: rtl/cia_multiword_adder.sv
// cia_multiword_adder: sequential W-bit adder feeding one N-bit chunk per cycle through CIA_Var_Size,
// carrying between chunks only through a register
module cia_multiword_adder
    import cia_pkg::*;
#(
    parameter int  N      = N_DEF,
    parameter int  CHUNKS = 4,
    localparam int W      = N * CHUNKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);
    localparam int IW = clog2(CHUNKS);
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic carry, last;
    logic [W-1:0] a_reg, b_reg;
    logic [N:1] add_a, add_b, add_s;
    logic add_c;
    assign add_a = a_reg[int'(idx)*N +: N];
    assign add_b = b_reg[int'(idx)*N +: N];
    assign last = idx == IW'(CHUNKS - 1);
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    CIA_Var_Size #(.N(N)) u_add (
        .sum  (add_s),
        .cout (add_c),
        .a    (add_a),
        .b    (add_b),
        .cin  (carry)
    );
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = in_valid ? BUSY : IDLE;
            BUSY:    state_nx = last ? DONE : BUSY;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_reg <= a;
                b_reg <= b;
                carry <= cin;
                idx   <= '0;
            end
            if (state == BUSY) begin
                sum[int'(idx)*N +: N] <= add_s;
                carry <= add_c;
                // idx parks on the last chunk so it never leaves 0..CHUNKS-1
                if (last) cout <= add_c;
                else idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cia_multiword_adder.sv
// tb_cia_multiword_adder: table-driven, directed and randomized checks against an arithmetic model
module tb_cia_multiword_adder;
    localparam int N = 64;
    localparam int CHUNKS = 4;
    localparam int W = N * CHUNKS;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, cin = 0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, cout, busy;
    logic [W-1:0] sum;
    int vectors = 0, miscompares = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;
    vec_t tbl[5];

    cia_multiword_adder #(.N(N), .CHUNKS(CHUNKS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // caller is at a negedge with the DUT idle; returns after the result handshake when out_ready is high
    task automatic txn(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic [W-1:0] es, input logic ec);
        int lat;
        a = ta; b = tb; cin = tc; in_valid = 1;
        chk({name, " in_ready"}, W'(in_ready), W'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, W'(lat), W'(CHUNKS));
        chk({name, " sum"}, {1'b0, sum}, {1'b0, es});
        chk({name, " cout"}, W'(cout), W'(ec));
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, " out_valid drop"}, W'(out_valid), W'(0));
            chk({name, " in_ready back"}, W'(in_ready), W'(1));
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb, hs;
        logic rc, hc;
        logic [W:0] model;
        int n;
        bit got1;
        tbl[0] = '{a: W'(1458996), b: W'(8547441), cin: 0, s: W'(10006437), c: 0};
        tbl[1] = '{a: {W{1'b1}}, b: '0, cin: 1, s: '0, c: 1};
        tbl[2] = '{a: W'(64'hffff_ffff_ffff_ffff), b: W'(1), cin: 0, s: W'(1) << 64, c: 0};
        tbl[3] = '{a: W'(5), b: W'(7), cin: 1, s: W'(13), c: 0};
        tbl[4] = '{a: W'(1) << 255, b: W'(1) << 255, cin: 0, s: '0, c: 1};

        #12;
        chk("reset in_ready", W'(in_ready), W'(1));
        chk("reset out_valid", W'(out_valid), W'(0));
        chk("reset busy", W'(busy), W'(0));
        chk("reset sum", {1'b0, sum}, '0);
        chk("reset cout", W'(cout), W'(0));
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            txn($sformatf("table%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].c);

        for (int i = 0; i < 24; i++) begin
            ra = rnd();
            rb = (i % 4 == 0) ? ~ra : rnd();
            rc = 1'($urandom);
            model = {1'b0, ra} + {1'b0, rb} + (W + 1)'(rc);
            txn($sformatf("rand%0d", i), ra, rb, rc, model[W-1:0], model[W]);
        end

        // result stalled in DONE while a new request knocks
        out_ready = 0;
        txn("stall", W'(100), W'(23), 1'b0, W'(123), 1'b0);
        for (int i = 0; i < 5; i++) begin
            a = rnd(); b = rnd(); cin = 1; in_valid = 1;
            @(posedge clk);
            @(negedge clk);
            chk("stall out_valid", W'(out_valid), W'(1));
            chk("stall in_ready", W'(in_ready), W'(0));
            chk("stall sum", {1'b0, sum}, (W + 1)'(123));
            chk("stall cout", W'(cout), W'(0));
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("stall release out_valid", W'(out_valid), W'(0));
        chk("stall release in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        @(negedge clk);
        chk("stall no capture busy", W'(busy), W'(0));

        // asynchronous reset in the second BUSY cycle
        a = W'(999); b = W'(1); cin = 0; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort out_valid", W'(out_valid), W'(0));
        chk("abort in_ready", W'(in_ready), W'(1));
        chk("abort busy", W'(busy), W'(0));
        chk("abort sum", {1'b0, sum}, '0);
        chk("abort cout", W'(cout), W'(0));
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        txn("after abort", W'(32'h4a7b), W'(32'h98cd), 1'b0, W'(32'he348), 1'b0);

        // back-to-back with in_valid held: second accept CHUNKS+2 edges after the first
        a = W'(5); b = W'(7); cin = 1; in_valid = 1;
        @(posedge clk);
        n = 0;
        got1 = 0;
        while (n < 30) begin
            @(negedge clk);
            if (out_valid && !got1) begin
                chk("b2b first sum", {1'b0, sum}, (W + 1)'(13));
                got1 = 1;
                a = W'(1) << 255; b = W'(1) << 255; cin = 0;
            end
            if (got1 && in_ready) break;
            @(posedge clk);
            n++;
        end
        chk("b2b spacing", W'(n + 1), W'(CHUNKS + 2));
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        hs = sum;
        hc = cout;
        chk("b2b second sum", {1'b0, hs}, '0);
        chk("b2b second cout", W'(hc), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
